// File: rtl/plru_req_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : plru_req_sched_if
// Description : Operand / handshake bundle between the request scheduler and
//               the uTLB PLRU replacement block.
//               master : scheduler side (drives operands, drive and release
//                        pulses; receives acknowledges and the victim vector)
//               slave  : PLRU side
// Ports       : plru_read_hit[DATA_WIDTH], plru_read_hit_vld, plru_refill_on,
//               plru_refill_vld, plru_drive_hit, plru_drive_miss,
//               plru_freeNext_end      (scheduler -> PLRU)
//               plru_free_hit, plru_free_miss,
//               plru_ref_num[DATA_WIDTH] (PLRU -> scheduler)
// Revision    : 1.0 - initial release
// ============================================================================
interface plru_req_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] plru_read_hit;
  logic                  plru_read_hit_vld;
  logic                  plru_refill_on;
  logic                  plru_refill_vld;
  logic                  plru_drive_hit;
  logic                  plru_drive_miss;
  logic                  plru_freeNext_end;
  logic                  plru_free_hit;
  logic                  plru_free_miss;
  logic [DATA_WIDTH-1:0] plru_ref_num;

  modport master (
    output plru_read_hit, plru_read_hit_vld, plru_refill_on, plru_refill_vld,
           plru_drive_hit, plru_drive_miss, plru_freeNext_end,
    input  plru_free_hit, plru_free_miss, plru_ref_num
  );

  modport slave (
    input  plru_read_hit, plru_read_hit_vld, plru_refill_on, plru_refill_vld,
           plru_drive_hit, plru_drive_miss, plru_freeNext_end,
    output plru_free_hit, plru_free_miss, plru_ref_num
  );
endinterface
`default_nettype wire

// File: rtl/plru_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : plru_req_sched
// Description : Scheduler in front of the 32-entry uTLB PLRU. Queues hit
//               updates in a small FIFO, latches one refill request, and
//               serialises them onto the PLRU drive/free handshake
//               (IDLE -> DRIVE -> WAIT -> REL). Returns the encoded victim
//               index for refills and flags a PLRU that never acknowledges.
// Ports       : forever_cpuclk, cpurst_b (async, active low)
//               hit_req_vld/way/rdy      hit-update request channel
//               refill_req_vld/rdy       refill request (pulse) channel
//               refill_rsp_vld/idx       victim index response (1-cycle)
//               plru                     PLRU operand/handshake bundle
//               busy, timeout_err, err_clr  status / sticky error
// Revision    : 1.0 - initial release
// ============================================================================
module plru_req_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int IDX_WIDTH    = 5,
  parameter int HQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 2,
  parameter int ACK_TIMEOUT  = 15
) (
  input  wire                   forever_cpuclk,
  input  wire                   cpurst_b,
  input  wire                   hit_req_vld,
  input  wire  [DATA_WIDTH-1:0] hit_req_way,
  output logic                  hit_req_rdy,
  input  wire                   refill_req_vld,
  output logic                  refill_req_rdy,
  output logic                  refill_rsp_vld,
  output logic [IDX_WIDTH-1:0]  refill_rsp_idx,
  plru_req_sched_if.master      plru,
  output logic                  busy,
  output logic                  timeout_err,
  input  wire                   err_clr
);

  localparam int PTR_W = (HQ_DEPTH > 1) ? $clog2(HQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(HQ_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int WD_W  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_REL   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [HQ_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [HQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pending_q, pending_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic                  is_miss_q, is_miss_d;
  logic [DATA_WIDTH-1:0] read_hit_q, read_hit_d;
  logic                  read_hit_vld_q, read_hit_vld_d;
  logic                  refill_on_q, refill_on_d;
  logic                  refill_vld_q, refill_vld_d;
  logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic                  timed_out_q, timed_out_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  grant_refill;
  logic                  grant_hit;
  logic                  ack_match;
  logic                  timeout_set;
  logic [WD_W-1:0]       wd_inc;
  logic [IDX_WIDTH-1:0]  lowest_idx;

  // ---------------------------------------------------------------- arbitration
  assign fifo_empty   = (count_q == '0);
  assign hit_req_rdy  = (count_q < CNT_W'(HQ_DEPTH));
  assign push         = hit_req_vld && hit_req_rdy;
  // A refill may overtake queued hits only STARVE_LIMIT times in a row.
  assign grant_refill = (state_q == S_IDLE) && pending_q &&
                        (fifo_empty || (starve_q < STV_W'(STARVE_LIMIT)));
  assign grant_hit    = (state_q == S_IDLE) && !grant_refill && !fifo_empty;
  assign pop          = grant_hit;

  // ---------------------------------------------------------------- hit FIFO
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = hit_req_way;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------- refill latch / starvation
  always_comb begin
    pending_d = pending_q;
    if (refill_req_vld && !pending_q) pending_d = 1'b1;
    // grant_refill implies pending_q, so set and clear never collide
    if (grant_refill)                 pending_d = 1'b0;

    starve_d = starve_q;
    if (grant_hit || fifo_empty) starve_d = '0;
    else if (grant_refill)       starve_d = starve_q + STV_W'(1);
  end

  // ---------------------------------------------------------------- transaction FSM
  assign ack_match = is_miss_q ? plru.plru_free_miss : plru.plru_free_hit;
  assign wd_inc    = wd_cnt_q + WD_W'(1);

  always_comb begin
    state_d        = state_q;
    is_miss_d      = is_miss_q;
    read_hit_d     = read_hit_q;
    read_hit_vld_d = read_hit_vld_q;
    refill_on_d    = refill_on_q;
    refill_vld_d   = refill_vld_q;
    wd_cnt_d       = wd_cnt_q;
    timed_out_d    = timed_out_q;
    timeout_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_refill) begin
          is_miss_d    = 1'b1;
          refill_on_d  = 1'b1;
          refill_vld_d = 1'b1;
          state_d      = S_DRIVE;
        end else if (grant_hit) begin
          is_miss_d      = 1'b0;
          read_hit_d     = mem_q[rd_ptr_q];
          read_hit_vld_d = 1'b1;
          state_d        = S_DRIVE;
        end
      end
      S_DRIVE: begin
        wd_cnt_d    = '0;
        timed_out_d = 1'b0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        wd_cnt_d = wd_inc;
        // An acknowledge on the final watchdog cycle still counts as a clean ack.
        if (ack_match) begin
          state_d = S_REL;
        end else if (wd_inc == WD_W'(ACK_TIMEOUT)) begin
          timeout_set = 1'b1;
          timed_out_d = 1'b1;
          state_d     = S_REL;
        end
      end
      S_REL: begin
        read_hit_d     = '0;
        read_hit_vld_d = 1'b0;
        refill_on_d    = 1'b0;
        refill_vld_d   = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timeout_err_d = timeout_err_q;
    if (timeout_set)  timeout_err_d = 1'b1;
    else if (err_clr) timeout_err_d = 1'b0;
  end

  // Lowest set bit wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    lowest_idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (plru.plru_ref_num[i]) lowest_idx = IDX_WIDTH'(i);
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q        <= S_IDLE;
      for (int i = 0; i < HQ_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pending_q      <= 1'b0;
      starve_q       <= '0;
      is_miss_q      <= 1'b0;
      read_hit_q     <= '0;
      read_hit_vld_q <= 1'b0;
      refill_on_q    <= 1'b0;
      refill_vld_q   <= 1'b0;
      wd_cnt_q       <= '0;
      timed_out_q    <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      pending_q      <= pending_d;
      starve_q       <= starve_d;
      is_miss_q      <= is_miss_d;
      read_hit_q     <= read_hit_d;
      read_hit_vld_q <= read_hit_vld_d;
      refill_on_q    <= refill_on_d;
      refill_vld_q   <= refill_vld_d;
      wd_cnt_q       <= wd_cnt_d;
      timed_out_q    <= timed_out_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign plru.plru_read_hit     = read_hit_q;
  assign plru.plru_read_hit_vld = read_hit_vld_q;
  assign plru.plru_refill_on    = refill_on_q;
  assign plru.plru_refill_vld   = refill_vld_q;
  assign plru.plru_drive_hit    = (state_q == S_DRIVE) && !is_miss_q;
  assign plru.plru_drive_miss   = (state_q == S_DRIVE) && is_miss_q;
  assign plru.plru_freeNext_end = (state_q == S_REL);

  assign refill_req_rdy = !pending_q;
  assign refill_rsp_vld = (state_q == S_REL) && is_miss_q;
  // A timed-out PLRU never produced a trustworthy victim vector.
  assign refill_rsp_idx = (refill_rsp_vld && !timed_out_q) ? lowest_idx : '0;
  assign busy           = (state_q != S_IDLE) || !fifo_empty || pending_q;
  assign timeout_err    = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_plru_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_plru_req_sched
// Description : Directed bench for plru_req_sched. Expected PLRU drive events
//               and refill responses are queued as stimulus is issued; a
//               monitor pops and compares them whenever the DUT presents a
//               drive pulse or a refill response. A small PLRU responder
//               acknowledges after a configurable number of WAIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plru_req_sched;

  localparam int DW = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hit_req_vld;
  logic [DW-1:0] hit_req_way;
  logic          hit_req_rdy;
  logic          refill_req_vld;
  logic          refill_req_rdy;
  logic          refill_rsp_vld;
  logic [IW-1:0] refill_rsp_idx;
  logic          busy;
  logic          timeout_err;
  logic          err_clr;

  always #5 clk = ~clk;

  plru_req_sched_if #(.DATA_WIDTH(DW)) plru_if ();

  plru_req_sched #(
    .DATA_WIDTH(DW), .IDX_WIDTH(IW), .HQ_DEPTH(4), .STARVE_LIMIT(2), .ACK_TIMEOUT(15)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .hit_req_vld    (hit_req_vld),
    .hit_req_way    (hit_req_way),
    .hit_req_rdy    (hit_req_rdy),
    .refill_req_vld (refill_req_vld),
    .refill_req_rdy (refill_req_rdy),
    .refill_rsp_vld (refill_rsp_vld),
    .refill_rsp_idx (refill_rsp_idx),
    .plru           (plru_if),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .err_clr        (err_clr)
  );

  typedef struct packed {
    logic          miss;
    logic [DW-1:0] vec;
  } exp_t;

  exp_t          drv_q[$];
  logic [IW-1:0] rsp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            rel_cnt = 0;
  int            ack_delay = 1;
  bit            ack_block = 1'b0;
  logic [DW-1:0] cur_vec = '0;
  logic [DW-1:0] hv [5] = '{32'h0000_0200, 32'h0000_0400, 32'h0000_0800,
                            32'h0000_1000, 32'h0000_2000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      cyc(1);
      n++;
    end
    chk("wait_idle_busy", busy, 0);
  endtask

  task automatic exp_drv(input logic miss, input logic [DW-1:0] vec);
    exp_t e;
    e.miss = miss;
    e.vec  = vec;
    drv_q.push_back(e);
  endtask

  task automatic send_hit(input logic [DW-1:0] vec);
    hit_req_way = vec;
    hit_req_vld = 1'b1;
    cyc(1);
    hit_req_vld = 1'b0;
  endtask

  task automatic pulse_refill();
    refill_req_vld = 1'b1;
    cyc(1);
    refill_req_vld = 1'b0;
  endtask

  // PLRU responder: acknowledges in WAIT cycle ack_delay (0 = never answer).
  initial begin
    plru_if.plru_free_hit  = 1'b0;
    plru_if.plru_free_miss = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (plru_if.plru_drive_hit || plru_if.plru_drive_miss) && ack_delay != 0) begin
        bit m;
        int n;
        m = plru_if.plru_drive_miss;
        @(posedge clk);
        #1;
        n = 1;
        while ((n < ack_delay || ack_block) && n < 40 && rst_n) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (rst_n) begin
          if (m) plru_if.plru_free_miss = 1'b1;
          else   plru_if.plru_free_hit  = 1'b1;
          @(posedge clk);
          #1;
          plru_if.plru_free_hit  = 1'b0;
          plru_if.plru_free_miss = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pops on every drive pulse and refill response.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (plru_if.plru_drive_hit || plru_if.plru_drive_miss) begin
          if (drv_q.size() == 0) begin
            flag("unexpected_drive");
          end else begin
            exp_t e;
            e = drv_q.pop_front();
            chk("drive_kind_miss", plru_if.plru_drive_miss, e.miss);
            chk("drive_kind_hit", plru_if.plru_drive_hit, !e.miss);
            if (e.miss) begin
              chk("refill_operand", {plru_if.plru_refill_on, plru_if.plru_refill_vld,
                                     plru_if.plru_read_hit_vld}, 3'b110);
            end else begin
              chk("hit_operand", plru_if.plru_read_hit, e.vec);
              chk("hit_operand_vld", {plru_if.plru_refill_vld, plru_if.plru_read_hit_vld}, 2'b01);
              cur_vec = e.vec;
            end
          end
        end else if (plru_if.plru_read_hit_vld) begin
          chk("hit_operand_stable", plru_if.plru_read_hit, cur_vec);
        end
        if (refill_rsp_vld) begin
          if (rsp_q.size() == 0) begin
            flag("unexpected_refill_rsp");
          end else begin
            logic [IW-1:0] ei;
            ei = rsp_q.pop_front();
            chk("refill_rsp_idx", refill_rsp_idx, ei);
          end
        end
        if (plru_if.plru_freeNext_end) rel_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got stuck, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int rel0;
    int hits;
    rst_n          = 1'b0;
    hit_req_vld    = 1'b0;
    hit_req_way    = '0;
    refill_req_vld = 1'b0;
    err_clr        = 1'b0;
    plru_if.plru_ref_num = '0;
    #3;
    // Reset state
    chk("rst_hit_rdy", hit_req_rdy, 1);
    chk("rst_refill_rdy", refill_req_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_rsp", {refill_rsp_vld, 27'd0, refill_rsp_idx}, 0);
    chk("rst_plru_ctl", {plru_if.plru_read_hit_vld, plru_if.plru_refill_on, plru_if.plru_refill_vld,
                         plru_if.plru_drive_hit, plru_if.plru_drive_miss, plru_if.plru_freeNext_end}, 0);
    chk("rst_read_hit", plru_if.plru_read_hit, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // Single hit, ack in 2nd WAIT cycle
    ack_delay = 2;
    exp_drv(1'b0, 32'h0000_0100);
    hit_req_way = 32'h0000_0100;
    hit_req_vld = 1'b1;
    cyc(1);
    hit_req_vld = 1'b0;
    n = 1;
    while (!plru_if.plru_drive_hit && n < 10) begin
      cyc(1);
      n++;
    end
    chk("hit_drive_cycle", n, 2);
    rel0 = rel_cnt;
    wait_idle(40);
    chk("hit_release_pulses", rel_cnt - rel0, 1);
    chk("hit_fifo_empty_rdy", hit_req_rdy, 1);

    // Single refill, victim bit 22
    ack_delay = 1;
    plru_if.plru_ref_num = 32'h0040_0000;
    exp_drv(1'b1, '0);
    rsp_q.push_back(5'd22);
    rel0 = rel_cnt;
    pulse_refill();
    chk("refill_rdy_pending", refill_req_rdy, 0);
    wait_idle(40);
    chk("refill_release_pulses", rel_cnt - rel0, 1);
    chk("refill_rdy_idle", refill_req_rdy, 1);

    // FIFO fill while PLRU stalls on an in-flight hit
    ack_block = 1'b1;
    exp_drv(1'b0, 32'h0000_0001);
    for (int i = 0; i < 5; i++) exp_drv(1'b0, hv[i]);
    rel0 = rel_cnt;
    send_hit(32'h0000_0001);
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      hit_req_way = hv[i];
      hit_req_vld = 1'b1;
      chk("fifo_accept_rdy", hit_req_rdy, 1);
      cyc(1);
    end
    hit_req_way = hv[4];
    chk("fifo_full_rdy", hit_req_rdy, 0);
    cyc(2);
    chk("fifo_full_hold", hit_req_rdy, 0);
    ack_block = 1'b0;
    n = 0;
    while (!hit_req_rdy && n < 20) begin
      cyc(1);
      n++;
    end
    chk("fifo_reopen", hit_req_rdy, 1);
    cyc(1);
    hit_req_vld = 1'b0;
    wait_idle(200);
    chk("fifo_release_pulses", rel_cnt - rel0, 6);

    // Arbitration: pending refill vs 3 queued hits, refill request held high
    plru_if.plru_ref_num = 32'h8000_0000;
    ack_block = 1'b1;
    exp_drv(1'b0, 32'h0000_0002);
    exp_drv(1'b1, '0);
    exp_drv(1'b1, '0);
    exp_drv(1'b0, 32'h0000_0010);
    exp_drv(1'b1, '0);
    exp_drv(1'b1, '0);
    exp_drv(1'b0, 32'h0000_0020);
    exp_drv(1'b1, '0);
    exp_drv(1'b0, 32'h0000_0040);
    repeat (5) rsp_q.push_back(5'd31);
    rel0 = rel_cnt;
    send_hit(32'h0000_0002);
    cyc(2);
    send_hit(32'h0000_0010);
    send_hit(32'h0000_0020);
    send_hit(32'h0000_0040);
    refill_req_vld = 1'b1;
    cyc(1);
    chk("arb_refill_pending", refill_req_rdy, 0);
    ack_block = 1'b0;
    hits = 0;
    n = 0;
    while (hits < 2 && n < 200) begin
      cyc(1);
      n++;
      if (plru_if.plru_drive_hit) hits++;
    end
    refill_req_vld = 1'b0;
    chk("arb_second_hit_seen", hits, 2);
    wait_idle(300);
    chk("arb_release_pulses", rel_cnt - rel0, 9);

    // Watchdog on a refill that is never acknowledged
    ack_delay = 0;
    plru_if.plru_ref_num = 32'h0000_0010;
    exp_drv(1'b1, '0);
    rsp_q.push_back(5'd0);
    pulse_refill();
    n = 1;
    while (!plru_if.plru_drive_miss && n < 10) begin
      cyc(1);
      n++;
    end
    chk("timeout_drive_cycle", n, 2);
    cyc(15);
    chk("timeout_err_before", timeout_err, 0);
    chk("no_release_in_wait", plru_if.plru_freeNext_end, 0);
    err_clr = 1'b1;
    cyc(1);
    chk("timeout_set_beats_clr", timeout_err, 1);
    chk("timeout_release", plru_if.plru_freeNext_end, 1);
    chk("timeout_rsp_vld", refill_rsp_vld, 1);
    chk("timeout_rsp_idx", refill_rsp_idx, 0);
    cyc(1);
    err_clr = 1'b0;
    chk("timeout_err_cleared", timeout_err, 0);
    wait_idle(20);

    // Asynchronous reset in the middle of WAIT
    exp_drv(1'b0, 32'h0000_0004);
    send_hit(32'h0000_0004);
    n = 1;
    while (!plru_if.plru_drive_hit && n < 10) begin
      cyc(1);
      n++;
    end
    chk("reset_test_drive_cycle", n, 2);
    cyc(2);
    rel0 = rel_cnt;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read_hit", plru_if.plru_read_hit, 0);
    chk("mid_rst_plru_ctl", {plru_if.plru_read_hit_vld, plru_if.plru_refill_on, plru_if.plru_refill_vld,
                             plru_if.plru_drive_hit, plru_if.plru_drive_miss, plru_if.plru_freeNext_end}, 0);
    chk("mid_rst_rdys", {hit_req_rdy, refill_req_rdy}, 2'b11);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp", refill_rsp_vld, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    chk("no_stale_release", rel_cnt - rel0, 0);
    chk("post_rst_busy", busy, 0);
    ack_delay = 1;
    exp_drv(1'b0, 32'h0000_0008);
    rel0 = rel_cnt;
    send_hit(32'h0000_0008);
    wait_idle(40);
    chk("post_rst_release", rel_cnt - rel0, 1);

    cyc(3);
    chk("drive_queue_drained", drv_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/plru_req_sched.md
Name: plru_req_sched

Overview:
- Scheduler in front of the 32-entry uTLB PLRU replacement block.
- Queues hit-update requests and latches refill requests, then arbitrates them one at a time onto the PLRU's drive/free handshake.
- Holds PLRU operands stable for each transaction, issues the freeNext_end release, and returns the victim way index for refills.
- Watchdog flags a PLRU that never acknowledges.

Parameters:
- DATA_WIDTH, 32, number of uTLB entries (one-hot vector width).
- IDX_WIDTH, 5, width of the encoded victim index (log2 DATA_WIDTH).
- HQ_DEPTH, 4, hit-update FIFO depth (power of two).
- STARVE_LIMIT, 2, maximum consecutive refills served while hits are pending.
- ACK_TIMEOUT, 15, WAIT cycles before the watchdog fires.

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- hit_req_vld  in  1  hit-update request
- hit_req_way  in  DATA_WIDTH  one-hot hit way
- hit_req_rdy  out  1  hit FIFO can accept
- refill_req_vld  in  1  single-cycle refill request pulse
- refill_req_rdy  out  1  no refill pending
- refill_rsp_vld  out  1  victim index valid, 1-cycle pulse
- refill_rsp_idx  out  IDX_WIDTH  encoded victim way
- plru_read_hit  out  DATA_WIDTH  hit vector to PLRU
- plru_read_hit_vld  out  1  hit operand valid
- plru_refill_on  out  1  refill operand
- plru_refill_vld  out  1  refill operand valid
- plru_drive_hit  out  1  hit drive pulse
- plru_drive_miss  out  1  miss drive pulse
- plru_free_hit  in  1  PLRU hit acknowledge
- plru_free_miss  in  1  PLRU miss acknowledge
- plru_freeNext_end  out  1  release pulse to PLRU
- plru_ref_num  in  DATA_WIDTH  PLRU victim vector (one-hot)
- busy  out  1  state != IDLE or FIFO non-empty or refill pending
- timeout_err  out  1  sticky watchdog flag
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset (cpurst_b low, asynchronous):
  - all outputs 0 except hit_req_rdy=1 and refill_req_rdy=1;
  - FIFO empty, refill pending cleared, FSM in IDLE, starve counter 0.
  - Reset mid-transaction abandons the transaction with no freeNext_end.
- Hit FIFO:
  - enqueue when hit_req_vld && hit_req_rdy;
  - hit_req_rdy = count < HQ_DEPTH, registered-count based, no same-cycle bypass.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Pointers wrap modulo HQ_DEPTH.
- Refill latch: refill_req_vld && refill_req_rdy sets pending. Pulses while pending are ignored.
- Arbitration, evaluated in IDLE only:
  - refill wins if pending and (FIFO empty or starve_cnt < STARVE_LIMIT); otherwise the FIFO head wins if non-empty.
  - starve_cnt increments on a refill grant while the FIFO is non-empty.
  - starve_cnt clears on any hit grant, or when the FIFO is empty.
- FSM states:
  - IDLE: on grant, load operands and go to DRIVE.
    - Hit: plru_read_hit = FIFO head, plru_read_hit_vld = 1, pop FIFO.
    - Refill: plru_refill_on = plru_refill_vld = 1, clear pending.
  - DRIVE (1 cycle): plru_drive_hit or plru_drive_miss = 1 matching the grant. Next state WAIT, with the watchdog counter cleared.
  - WAIT: operands held stable. Exit to REL when the matching free input is sampled high; a free on the non-matching input is ignored. Counter increments each cycle. Reaching ACK_TIMEOUT sets timeout_err and forces REL.
  - REL (1 cycle):
    - plru_freeNext_end = 1; operand valids cleared at exit.
    - For a miss, refill_rsp_vld = 1. refill_rsp_idx is the lowest set bit of plru_ref_num, sampled in REL; it is 0 if plru_ref_num is all-zero or on timeout.
    - Next state IDLE.
- Latency: minimum 4 cycles per transaction (IDLE grant to REL exit, with an immediate ack). Back-to-back grants are allowed from the IDLE cycle following REL.
- timeout_err: set has priority over err_clr in the same cycle.
- refill_req_rdy = !pending. A new refill may be latched during an in-flight refill (pending is clear after grant).

Test Plan:
- Hit: single hit_req_way=32'h0000_0100, free_hit in the 2nd WAIT cycle -> drive_hit pulse at cycle 2, plru_read_hit=32'h100 held through WAIT, one freeNext_end pulse, FIFO empty, busy falls.
- Refill: refill pulse, plru_ref_num=32'h0040_0000 with free_miss -> drive_miss, then refill_rsp_vld for 1 cycle with refill_rsp_idx=22.
- FIFO and arbitration:
  - 5 hit requests in consecutive cycles with PLRU acks stalled -> hit_req_rdy low after 4 accepted, 5th held and accepted after the first pop.
  - Refill pending with 3 hits queued and continuous refill pulses -> grant order R,R,H,R,R,H (STARVE_LIMIT=2).
- Timeout: no free_* for 15 WAIT cycles on a refill -> timeout_err=1, freeNext_end pulse, refill_rsp_idx=0. A simultaneous err_clr keeps the flag; err_clr a cycle later clears it.
- Reset: cpurst_b asserted during WAIT -> all outputs 0 immediately with rdy outputs 1; after release the FSM is in IDLE and no stale freeNext_end or rsp is emitted.
